// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame/data widths, command codes and master FSM states.
package spi_pkg;

  localparam int SPI_FRAME_W = 10;
  localparam int SPI_DATA_W  = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT_RD,
    ST_RECV,
    ST_DONE
  } spi_mst_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Request side and serial side of the SPI master, bundled for port connection.
interface spi_master_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
);

  // Handshake: start/frame form a request taken only on an edge where ready=1
  // (frame must be stable on that edge); start while ready=0 is dropped, never
  // queued. done, rd_valid and timeout are single-cycle pulses with no back-pressure.
  logic               start;
  logic [FRAME_W-1:0] frame;
  logic               ready;
  logic               ss_n;
  logic               MOSI;
  logic               MISO;
  logic               miso_valid;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               done;
  logic               timeout;

  modport master (
    input  start, frame, MISO, miso_valid,
    output ready, ss_n, MOSI, rd_data, rd_valid, done, timeout
  );

  modport slave (
    output start, frame, MISO, miso_valid,
    input  ready, ss_n, MOSI, rd_data, rd_valid, done, timeout
  );

endinterface

// File: rtl/spi_master.sv
// SPI master: serialises a 10-bit command frame MSB first under ss_n and, for
// read-data commands, collects the 8-bit reply qualified by miso_valid.
module spi_master
  import spi_pkg::*;
#(
  parameter int FRAME_W    = SPI_FRAME_W,
  parameter int DATA_W     = SPI_DATA_W,
  parameter int RD_TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           rst,
  spi_master_if.master   bus,
  output spi_mst_state_t dbg_state
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  spi_mst_state_t     state, state_nxt;
  spi_cmd_t           cmd_q;
  logic [FRAME_W-1:0] tx_sr;
  logic [3:0]         bit_cnt;
  logic [DATA_W-2:0]  rx_sr;
  logic [TW-1:0]      to_cnt;
  logic [DATA_W-1:0]  rd_data_q;
  logic               ss_n_q, mosi_q, rd_valid_q, done_q, timeout_q;
  logic               accept;

  assign accept = bus.start && (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.start) state_nxt = ST_SETUP;
      ST_SETUP:   state_nxt = ST_SHIFT;
      ST_SHIFT:   if (bit_cnt == 4'd0)
                    state_nxt = (cmd_q == CMD_RD_DATA) ? ST_WAIT_RD : ST_DONE;
      // A reply arriving on the last allowed cycle still wins over the timeout.
      ST_WAIT_RD: if (bus.miso_valid)                       state_nxt = ST_RECV;
                  else if (to_cnt == TW'(RD_TIMEOUT - 1))   state_nxt = ST_DONE;
      ST_RECV:    if (bit_cnt == 4'd0) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_q      <= CMD_WR_ADDR;
      tx_sr      <= '0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      to_cnt     <= '0;
      rd_data_q  <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state <= state_nxt;

      // Serial outputs are registered from the next state so they line up with it.
      ss_n_q     <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
      mosi_q     <= (state_nxt == ST_SHIFT) ? tx_sr[FRAME_W-1] : 1'b0;
      done_q     <= (state_nxt == ST_DONE);
      rd_valid_q <= (state == ST_RECV) && (state_nxt == ST_DONE);
      timeout_q  <= (state == ST_WAIT_RD) && (state_nxt == ST_DONE);

      if (accept) begin
        tx_sr <= bus.frame;
        cmd_q <= spi_cmd_t'(bus.frame[FRAME_W-1 -: 2]);
      end else if (state_nxt == ST_SHIFT) begin
        tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
      end

      case (state)
        ST_SETUP: bit_cnt <= 4'(FRAME_W - 1);
        ST_SHIFT: begin
          bit_cnt <= bit_cnt - 4'd1;
          to_cnt  <= '0;
        end
        ST_WAIT_RD: begin
          to_cnt <= to_cnt + TW'(1);
          if (bus.miso_valid) begin
            rx_sr   <= {rx_sr[DATA_W-3:0], bus.MISO};
            bit_cnt <= 4'(DATA_W - 2);
          end
        end
        ST_RECV: begin
          rx_sr   <= {rx_sr[DATA_W-3:0], bus.MISO};
          bit_cnt <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd0) rd_data_q <= {rx_sr, bus.MISO};
        end
        default: ;
      endcase
    end
  end

  assign bus.ready    = (state == ST_IDLE);
  assign bus.ss_n     = ss_n_q;
  assign bus.MOSI     = mosi_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;
  assign dbg_state    = state;

endmodule

// File: doc/spi_master.md
# spi_master

SPI master that drives the team's 10-bit SPI slave protocol from a parallel request interface. It sits between the system-side controller and the SPI slave/RAM subsystem and shares the system clock with the slave, so there is no separate SCLK. It serialises a command frame on MOSI under `ss_n`. For read-data commands it also collects the 8-bit reply from MISO, which arrives qualified by the slave's `miso_valid`.

## Interface
- `FRAME_W`, 10: request frame width; bits [9:8] are the command, bits [7:0] are the payload.
- `DATA_W`, 8: width of the read reply.
- `RD_TIMEOUT`, 32: maximum number of cycles to wait for `miso_valid` during a read.

- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request strobe; accepted only when `ready`=1.
- `frame` in FRAME_W: request word, sampled on the accept edge.
- `ready` out 1: high only in IDLE.
- `ss_n` out 1: slave select, active low, registered.
- `MOSI` out 1: serial data to the slave, MSB first, registered.
- `MISO` in 1: serial data from the slave.
- `miso_valid` in 1: slave's MISO qualifier.
- `rd_data` out DATA_W: last received read byte; holds its value between reads.
- `rd_valid` out 1: one-cycle pulse when `rd_data` is updated.
- `done` out 1: one-cycle pulse at the end of every transaction.
- `timeout` out 1: one-cycle pulse, coincident with `done`, when a read times out.

## Operation
- Commands, from `frame[9:8]`:
  - 00 = write address; 01 = write data; 10 = read address; 11 = read data.
  - Only 11 has a receive phase. All others are write-only frames.
- States and transitions:
  - IDLE → SETUP on `start`.
  - SETUP → SHIFT after 1 cycle.
  - SHIFT → DONE after 10 bits when cmd≠11; SHIFT → WAIT_RD when cmd=11.
  - WAIT_RD → RECV on `miso_valid`=1, or → DONE on timeout.
  - RECV → DONE after 8 samples.
  - DONE → IDLE after 1 cycle.
- Signal values per state:
  - IDLE and DONE: `ss_n`=1, `MOSI`=0.
  - SETUP, SHIFT, WAIT_RD, RECV: `ss_n`=0.
  - `MOSI`=0 in every state except SHIFT.
- Transmit: the frame is latched into a shift register on accept and shifted left one bit per cycle in SHIFT. A 4-bit counter runs from 9 down to 0.
- Receive:
  - `MISO` is sampled on the first edge where `miso_valid`=1 (this is the MSB) and on the following 7 edges, shifting in left.
  - `miso_valid` is not re-checked during RECV.
  - `miso_valid` is ignored in all other states.
- Timeout:
  - The counter is `$clog2(RD_TIMEOUT+1)` bits wide and is cleared on entry to WAIT_RD.
  - If it reaches RD_TIMEOUT with no `miso_valid`: go to DONE, pulse `timeout` and `done`, and leave `rd_data` unchanged with no `rd_valid`.
- `start` is ignored while `ready`=0; no queuing.
- Reset values: `ss_n`=1, `MOSI`=0, `ready`=1, `rd_data`=0, `rd_valid`=0, `done`=0, `timeout`=0, and state=IDLE.
- Reset mid-transaction: at the next edge the FSM returns to IDLE with `ss_n`=1. Any partial byte is discarded and no `done` pulse is generated.

## Timing
- Edge numbering: accept happens at edge E0 (`start`&&`ready`). Register outputs after edge En are described as "after En".
- Frame phase:
  - After E0: SETUP, `ss_n`=0, `ready`=0.
  - After E1+k, for k=0..9: `MOSI`=`frame[9-k]`. So `frame[9]` is on the line during the slave's command-check cycle.
- Write-only end:
  - After E11: DONE, `ss_n`=1, `done`=1.
  - After E12: IDLE, `ready`=1.
  - Accept-to-ready latency is 12 cycles.
- Read end:
  - After E11: WAIT_RD.
  - If `miso_valid` is first high at edge Ev, bits are sampled at Ev..Ev+7.
  - After Ev+7: DONE, `rd_data` updated, `rd_valid`=`done`=1, `ss_n`=1.
- `ss_n` stays high for at least 2 cycles between frames.
- `start` held high continuously: a new frame is accepted on the first edge where `ready`=1.

## Structure
- Shared package `spi_pkg`:
  - `spi_cmd_t` enum for the four command codes.
  - `spi_mst_state_t` enum for the master states.
  - Constants `SPI_FRAME_W`=10 and `SPI_DATA_W`=8, also used by the slave.
- Single flat module; no sub-module is warranted. It contains the FSM, the TX shift register with bit counter, the RX shift register, and the timeout counter.

## Test plan
- Write data: `frame`=10'b01_1010_0101.
  - MOSI, starting the cycle after SETUP, must read 0,1,1,0,1,0,0,1,0,1.
  - `done` pulses after E11; `ready` returns after E12.
  - `rd_valid` never fires.
- Read data with a looped-back slave model: `frame`=10'b11_0000_0000, and the slave presents 0xC3 with `miso_valid` starting 4 cycles after WAIT_RD entry.
  - Required: `rd_data`=0xC3, with `rd_valid`=`done`=1 in the same cycle.
  - `ss_n` rises in that same cycle.
- Read timeout: cmd 11 with `miso_valid` held at 0.
  - `timeout`=`done`=1 exactly RD_TIMEOUT cycles after WAIT_RD entry.
  - `rd_data` keeps its previous value.
- Reset mid-transaction: assert `rst` during bit 5 of SHIFT.
  - After the next edge: `ss_n`=1, `MOSI`=0, `ready`=1.
  - No `done` pulse.
- Busy and back-to-back requests:
  - `start` pulsed during SHIFT with a different frame is ignored.
  - `start` held high across two frames (10'h0A5 then 10'h1FF) gives 2 cycles of `ss_n`=1 between them, and both frames are serialised correctly.
